// File: rtl/ctr_stream_cipher_pkg.sv
// ---------------------------------------------------------------------------
// ctr_stream_cipher_pkg
// Shared types and helpers for the multi-channel counter-mode stream cipher.
//   byte_t       : 8-bit data / counter-block type
//   REUSE_LIMIT  : bytes of keystream a channel may consume per key load
//   lane_cb()    : counter block value seen by byte lane i, modulo 256
// ---------------------------------------------------------------------------
package ctr_stream_cipher_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned REUSE_LIMIT = 256;

  function automatic byte_t lane_cb(input byte_t cb, input int unsigned i);
    return byte_t'(32'(cb) + i);
  endfunction

endpackage

// File: rtl/ctr_stream_cipher_sbox.sv
// ---------------------------------------------------------------------------
// sbox
// Combinational AES byte substitution: multiplicative inverse in GF(2^8)
// (polynomial 0x11B, inverse of 0 is 0) followed by the AES affine map.
// Ports:
//   in_byte  in  8 : byte to substitute
//   out_byte out 8 : substituted byte
// ---------------------------------------------------------------------------
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic       hi;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // x^254 == x^-1 for x != 0, and yields 0 for x == 0.
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/ctr_stream_cipher.sv
// ---------------------------------------------------------------------------
// ctr_stream_cipher
// Multi-channel counter-mode stream cipher. Each channel keeps an 8-bit
// counter block loaded from a key; byte i of a beat is XORed with
// sbox(cb + i) and the counter then advances by the beat length.
// One-cycle latency, registered output, full valid/ready backpressure.
//
// Parameters: DATA_BYTES (lanes per beat), NUM_CH (channels).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   key_in/key_ch/key     : load key into channel key_ch (priority over data)
//   din_valid/din_ready   : input handshake (din_ready is combinational)
//   din_ch/din_len/din_data : input channel, byte count, plaintext
//   dout_valid/dout_ready : output handshake
//   dout_ch/dout_len/dout_data : channel echo, length echo, ciphertext
//   ks_reuse              : sticky per-channel keystream-reuse flags
// Build option: CTR_STREAM_CIPHER_REUSE_DET_EN enables per-channel byte
// counting and the ks_reuse flags; otherwise ks_reuse is tied to 0.
// ---------------------------------------------------------------------------
module ctr_stream_cipher
  import ctr_stream_cipher_pkg::*;
#(
  parameter  int unsigned DATA_BYTES = 4,
  parameter  int unsigned NUM_CH     = 4,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LEN_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_in,
  input  logic [CH_W-1:0]         key_ch,
  input  logic [7:0]              key,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [CH_W-1:0]         din_ch,
  input  logic [LEN_W-1:0]        din_len,
  input  logic [8*DATA_BYTES-1:0] din_data,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [CH_W-1:0]         dout_ch,
  output logic [LEN_W-1:0]        dout_len,
  output logic [8*DATA_BYTES-1:0] dout_data,
  output logic [NUM_CH-1:0]       ks_reuse
);

  byte_t                   cb_q [NUM_CH];
  byte_t                   cur_cb;
  logic [NUM_CH-1:0]       key_sel;
  logic [NUM_CH-1:0]       din_sel;
  logic                    ch_ok;
  logic                    len_ok;
  logic                    beat_fire;
  logic                    beat_ok;
  byte_t                   lane_in [DATA_BYTES];
  byte_t                   ks      [DATA_BYTES];
  logic [8*DATA_BYTES-1:0] ct;

  // Channel decode by match against every index: out-of-range selectors hit
  // nothing, so they are ignored without a separate range compare.
  always_comb begin
    key_sel = '0;
    din_sel = '0;
    cur_cb  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      key_sel[c] = key_in && (key_ch == CH_W'(c));
      din_sel[c] = (din_ch == CH_W'(c));
      if (din_ch == CH_W'(c)) cur_cb = cb_q[c];
    end
  end

  assign ch_ok     = |din_sel;
  assign len_ok    = (din_len != '0) && ({1'b0, din_len} <= (LEN_W+1)'(DATA_BYTES));
  assign din_ready = !key_in && (!dout_valid || dout_ready);
  assign beat_fire = din_valid && din_ready;
  assign beat_ok   = beat_fire && ch_ok && len_ok;

  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    assign lane_in[g] = lane_cb(cur_cb, g);
    sbox u_sbox (
      .in_byte  (lane_in[g]),
      .out_byte (ks[g])
    );
  end

  always_comb begin
    ct = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (32'(din_len) > i) ct[8*i +: 8] = din_data[8*i +: 8] ^ ks[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cb_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (key_sel[c])                cb_q[c] <= key;
        else if (beat_ok && din_sel[c]) cb_q[c] <= lane_cb(cur_cb, 32'(din_len));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      dout_len   <= '0;
      dout_data  <= '0;
    end else if (beat_ok) begin
      dout_valid <= 1'b1;
      dout_ch    <= din_ch;
      dout_len   <= din_len;
      dout_data  <= ct;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef CTR_STREAM_CIPHER_REUSE_DET_EN
  logic [8:0]        cnt_q [NUM_CH];
  logic [8:0]        cur_cnt;
  logic [8:0]        cnt_next;
  logic [9:0]        cnt_sum;
  logic              over;
  logic [NUM_CH-1:0] reuse_q;

  always_comb begin
    cur_cnt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (din_sel[c]) cur_cnt = cnt_q[c];
    end
    cnt_sum  = {1'b0, cur_cnt} + 10'(din_len);
    over     = cnt_sum > 10'(REUSE_LIMIT);
    cnt_next = over ? 9'(REUSE_LIMIT) : cnt_sum[8:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      reuse_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (key_sel[c]) begin
          cnt_q[c]   <= '0;
          reuse_q[c] <= 1'b0;
        end else if (beat_ok && din_sel[c]) begin
          cnt_q[c] <= cnt_next;
          if (over) reuse_q[c] <= 1'b1;
        end
      end
    end
  end

  assign ks_reuse = reuse_q;
`else
  assign ks_reuse = '0;
`endif

endmodule

// File: tb/tb_ctr_stream_cipher.sv
// ---------------------------------------------------------------------------
// tb_ctr_stream_cipher
// Self-checking bench: table of known AES-sbox vectors, directed multi-cycle
// sequences, and randomized traffic checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_ctr_stream_cipher;

  localparam int unsigned DB    = 4;
  localparam int unsigned NC    = 4;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned LEN_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_in = 1'b0;
  logic [CH_W-1:0]   key_ch = '0;
  logic [7:0]        key = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic [CH_W-1:0]   din_ch = '0;
  logic [LEN_W-1:0]  din_len = '0;
  logic [8*DB-1:0]   din_data = '0;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic [CH_W-1:0]   dout_ch;
  logic [LEN_W-1:0]  dout_len;
  logic [8*DB-1:0]   dout_data;
  logic [NC-1:0]     ks_reuse;

  ctr_stream_cipher #(.DATA_BYTES(DB), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_ch(key_ch), .key(key),
    .din_valid(din_valid), .din_ready(din_ready), .din_ch(din_ch),
    .din_len(din_len), .din_data(din_data), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_ch(dout_ch), .dout_len(dout_len),
    .dout_data(dout_data), .ks_reuse(ks_reuse)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int sbox_m [256];
  int mcb    [NC];
  int mcnt   [NC];
  logic [NC-1:0] mflag;

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [LEN_W-1:0] len;
    logic [8*DB-1:0]  data;
  } beat_t;
  beat_t q[$];

  // AES sbox from log/antilog tables over generator 3.
  task automatic build_sbox();
    int ex [256];
    int lg [256];
    int x, inv, s;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ (((x << 1) ^ ((x & 8'h80) != 0 ? 'h11b : 0)) & 'hff);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 0 : ex[(255 - lg[a]) % 255];
      s = inv;
      for (int n = 1; n <= 4; n++) s = s ^ (((inv << n) | (inv >> (8 - n))) & 'hff);
      sbox_m[a] = s ^ 'h63;
    end
  endtask

  task automatic model_reset();
    q.delete();
    mflag = '0;
    for (int c = 0; c < NC; c++) begin
      mcb[c]  = 0;
      mcnt[c] = 0;
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance model.
  task automatic step(input logic ki, input logic [CH_W-1:0] kc, input logic [7:0] k,
                      input logic dv, input logic [CH_W-1:0] dc, input logic [LEN_W-1:0] dl,
                      input logic [8*DB-1:0] dd, input logic dr);
    logic exp_ready;
    logic [8*DB-1:0] e;
    int n;
    @(negedge clk);
    key_in = ki; key_ch = kc; key = k;
    din_valid = dv; din_ch = dc; din_len = dl; din_data = dd;
    dout_ready = dr;
    #1;
    exp_ready = !ki && (q.size() == 0 || dr);
    chk("din_ready", din_ready, exp_ready);
    chk("dout_valid", dout_valid, q.size() != 0);
    if (q.size() != 0 && dout_valid === 1'b1) begin
      chk("dout_data", dout_data, q[0].data);
      chk("dout_ch", dout_ch, q[0].ch);
      chk("dout_len", dout_len, q[0].len);
    end
    chk("ks_reuse", ks_reuse, mflag);
    if (q.size() != 0 && dr) void'(q.pop_front());
    if (ki) begin
      mcb[kc] = k; mcnt[kc] = 0; mflag[kc] = 1'b0;
    end else if (exp_ready && dv && dl >= 1 && dl <= DB) begin
      n = int'(dl);
      e = '0;
      for (int i = 0; i < n; i++) e[8*i +: 8] = dd[8*i +: 8] ^ 8'(sbox_m[(mcb[dc] + i) % 256]);
      mcb[dc] = (mcb[dc] + n) % 256;
`ifdef CTR_STREAM_CIPHER_REUSE_DET_EN
      if (mcnt[dc] + n > 256) mflag[dc] = 1'b1;
      mcnt[dc] = (mcnt[dc] + n > 256) ? 256 : mcnt[dc] + n;
`endif
      q.push_back('{ch: dc, len: dl, data: e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, '0, 8'h00, 1'b0, '0, '0, '0, dr);
  endtask

  task automatic do_key(input logic [CH_W-1:0] c, input logic [7:0] k);
    step(1'b1, c, k, 1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic beat(input logic [CH_W-1:0] c, input logic [LEN_W-1:0] l,
                      input logic [8*DB-1:0] d, input logic dr);
    step(1'b0, '0, 8'h00, 1'b1, c, l, d, dr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_in = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    #1;
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_dout_data", dout_data, '0);
    chk("rst_dout_ch", dout_ch, '0);
    chk("rst_dout_len", dout_len, '0);
    chk("rst_ks_reuse", ks_reuse, '0);
    chk("rst_din_ready", din_ready, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    logic             load;
    logic [CH_W-1:0]  ch;
    logic [7:0]       k;
    logic [LEN_W-1:0] len;
    logic [8*DB-1:0]  data;
    logic             exp_valid;
    logic [8*DB-1:0]  exp;
  } tv_t;
  tv_t tv [10];

  logic exp_flag;

  initial begin
    tv[0] = '{1'b1, 2'd1, 8'hFE, 3'd4, 32'h00000000, 1'b1, 32'h7C6316BB};
    tv[1] = '{1'b0, 2'd1, 8'h00, 3'd4, 32'h00000000, 1'b1, 32'h6BF27B77};
    tv[2] = '{1'b1, 2'd3, 8'h20, 3'd2, 32'h00000000, 1'b1, 32'h0000FDB7};
    tv[3] = '{1'b0, 2'd3, 8'h00, 3'd0, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tv[4] = '{1'b0, 2'd3, 8'h00, 3'd5, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tv[5] = '{1'b0, 2'd3, 8'h00, 3'd4, 32'h00000000, 1'b1, 32'h3F362693};
    tv[6] = '{1'b1, 2'd0, 8'h10, 3'd4, 32'hFFFFFFFF, 1'b1, 32'h82367D35};
    tv[7] = '{1'b1, 2'd2, 8'h80, 3'd1, 32'h000000AA, 1'b1, 32'h00000067};
    tv[8] = '{1'b1, 2'd1, 8'h00, 3'd3, 32'h12345678, 1'b1, 32'h00432A1B};
    tv[9] = '{1'b1, 2'd2, 8'hFF, 3'd4, 32'h00000000, 1'b1, 32'h777C6316};

    build_sbox();
    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      if (tv[i].load) do_key(tv[i].ch, tv[i].k);
      beat(tv[i].ch, tv[i].len, tv[i].data, 1'b1);
      chk($sformatf("tv%0d_valid", i), dout_valid, tv[i].exp_valid);
      if (tv[i].exp_valid) begin
        chk($sformatf("tv%0d_data", i), dout_data, tv[i].exp);
        chk($sformatf("tv%0d_ch", i), dout_ch, tv[i].ch);
        chk($sformatf("tv%0d_len", i), dout_len, tv[i].len);
      end
    end
    idle(1'b1);

    // Interleaved channels, back-to-back beats.
    do_key(2'd0, 8'h10);
    do_key(2'd2, 8'h80);
    for (int i = 0; i < 6; i++) beat((i % 2 == 0) ? 2'd0 : 2'd2, 3'd4, $urandom, 1'b1);
    idle(1'b1);

    // Backpressure: three stalled cycles with din_valid held.
    beat(2'd1, 3'd4, 32'hA5A5A5A5, 1'b1);
    for (int i = 0; i < 3; i++) beat(2'd1, 3'd4, 32'h5A5A5A5A, 1'b0);
    beat(2'd1, 3'd4, 32'h5A5A5A5A, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Key load blocks the concurrent data beat; the beat then uses the new key.
    step(1'b1, 2'd1, 8'h55, 1'b1, 2'd1, 3'd4, 32'h01020304, 1'b1);
    chk("keyprio_no_out", dout_valid, 1'b0);
    beat(2'd1, 3'd4, 32'h01020304, 1'b1);
    chk("keyprio_data", dout_data, {8'(sbox_m[8'h58]) ^ 8'h01, 8'(sbox_m[8'h57]) ^ 8'h02,
                                    8'(sbox_m[8'h56]) ^ 8'h03, 8'(sbox_m[8'h55]) ^ 8'h04});
    idle(1'b1);

    // Key load on a channel whose beat is held in the output register.
    beat(2'd3, 3'd4, 32'h11111111, 1'b0);
    step(1'b1, 2'd3, 8'hC0, 1'b0, '0, '0, '0, 1'b0);
    idle(1'b1);
    beat(2'd3, 3'd4, 32'h22222222, 1'b1);
    idle(1'b1);

    // Keystream reuse: 256 bytes allowed, the next beat trips the flag.
`ifdef CTR_STREAM_CIPHER_REUSE_DET_EN
    exp_flag = 1'b1;
`else
    exp_flag = 1'b0;
`endif
    do_key(2'd0, 8'h00);
    for (int i = 0; i < 64; i++) beat(2'd0, 3'd4, $urandom, 1'b1);
    idle(1'b1);
    chk("reuse_at_limit", ks_reuse[0], 1'b0);
    beat(2'd0, 3'd1, $urandom, 1'b1);
    idle(1'b1);
    chk("reuse_over_limit", ks_reuse[0], exp_flag);
    do_key(2'd0, 8'h33);
    idle(1'b1);
    chk("reuse_cleared", ks_reuse[0], 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 11) == 0), 2'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), 2'($urandom),
           ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(1, 4)),
           $urandom, ($urandom_range(0, 9) < 7));
    end

    // Reset with a beat held mid-stream: beat dropped and counters cleared.
    beat(2'd2, 3'd4, 32'hCAFEF00D, 1'b0);
    do_reset();
    idle(1'b1);
    beat(2'd2, 3'd4, 32'h00000000, 1'b1);
    chk("post_rst_data", dout_data, 32'h6BF27B77 ^ 32'h6BF27B77 ^ {8'(sbox_m[3]), 8'(sbox_m[2]), 8'(sbox_m[1]), 8'(sbox_m[0])});
    idle(1'b1);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
